// File: rtl/square_tone_gen.sv
// Multi-channel square-wave tone generator with a 1-bit mixed speaker output.
// Latency: config takes effect at the accept edge; every output is a register (one clock from its inputs).
// Backpressure: cfg_ready drops for one clock after each accept, so at most one write per two clocks.
//
// Ports:
//   CLOCK_50, RESET_N             clock (posedge) and synchronous active-low reset
//   cfg_valid/cfg_ready           config write handshake; cfg_ch/cfg_half_period/cfg_duration sampled at accept
//   enable                        global gate; 0 freezes every channel and forces tone_out/mix_out low
//   tone_out, busy                per-channel square wave and RUN indication
//   mix_out                       mixed speaker drive
// Optional feature macro: TONE_MIX_EN (sigma-delta mix of all channels instead of a plain OR).
module square_tone_gen #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 20,
    parameter int DUR_W  = 24,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_half_period,
    input  logic [DUR_W-1:0]  cfg_duration,
    input  logic              enable,
    output logic [NUM_CH-1:0] tone_out,
    output logic [NUM_CH-1:0] busy,
    output logic              mix_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    ch_state_e          state_q [NUM_CH];
    ch_state_e          state_d [NUM_CH];
    logic [DIV_W-1:0]   hp_q    [NUM_CH];
    logic [DIV_W-1:0]   hp_d    [NUM_CH];
    logic [DIV_W-1:0]   phase_q [NUM_CH];
    logic [DIV_W-1:0]   phase_d [NUM_CH];
    logic [DUR_W-1:0]   dur_q   [NUM_CH];
    logic [DUR_W-1:0]   dur_d   [NUM_CH];

    // wave_q is the free-running square wave; tone_q is the gated copy seen at the pins.
    logic [NUM_CH-1:0]  wave_q, wave_d;
    logic [NUM_CH-1:0]  tone_q, tone_d;
    logic [NUM_CH-1:0]  busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               mix_q, mix_d;
    logic               accept;

    // ------------------------------------------------------------------
    // Handshake and per-channel next state
    // ------------------------------------------------------------------
    always_comb begin
        accept  = cfg_valid & ready_q;
        ready_d = ready_q ? ~cfg_valid : 1'b1;
        wave_d  = wave_q;
        busy_d  = '0;

        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            hp_d[c]    = hp_q[c];
            phase_d[c] = phase_q[c];
            dur_d[c]   = dur_q[c];

            // Out-of-range cfg_ch matches no channel, so such a write is a no-op.
            if (accept && (int'(cfg_ch) == c)) begin
                phase_d[c] = '0;
                wave_d[c]  = 1'b0;
                if (cfg_half_period == '0) begin
                    state_d[c] = ST_IDLE;
                    hp_d[c]    = '0;
                    dur_d[c]   = '0;
                end else begin
                    state_d[c] = ST_RUN;
                    hp_d[c]    = cfg_half_period;
                    dur_d[c]   = cfg_duration;
                end
            end else begin
                case (state_q[c])
                    ST_RUN: begin
                        if (enable) begin
                            if (dur_q[c] == DUR_W'(1)) begin
                                // Last enabled clock of a timed note.
                                state_d[c] = ST_IDLE;
                                hp_d[c]    = '0;
                                phase_d[c] = '0;
                                dur_d[c]   = '0;
                                wave_d[c]  = 1'b0;
                            end else begin
                                // dur==0 means continuous: never decremented.
                                if (dur_q[c] != '0) begin
                                    dur_d[c] = dur_q[c] - DUR_W'(1);
                                end
                                if (phase_q[c] == hp_q[c] - DIV_W'(1)) begin
                                    phase_d[c] = '0;
                                    wave_d[c]  = ~wave_q[c];
                                end else begin
                                    phase_d[c] = phase_q[c] + DIV_W'(1);
                                end
                            end
                        end
                    end
                    default: begin
                        hp_d[c]    = '0;
                        phase_d[c] = '0;
                        dur_d[c]   = '0;
                        wave_d[c]  = 1'b0;
                    end
                endcase
            end

            busy_d[c] = (state_d[c] == ST_RUN);
        end

        // Gate with the enable sampled at this edge: pins go low from the next edge.
        tone_d = wave_d & {NUM_CH{enable}};
    end

    // ------------------------------------------------------------------
    // Mixer: works on the registered pin values, so mix_out trails tone_out
    // by one clock; the enable gate keeps it low on the same edge as tone_out.
    // ------------------------------------------------------------------
`ifdef TONE_MIX_EN
    localparam int ACC_W = CH_W + 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] pop;
    logic [ACC_W:0]   sum;

    always_comb begin
        pop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pop = pop + ACC_W'(tone_q[c]);
        end
        sum = {1'b0, acc_q} + {1'b0, pop};
        if (sum >= (ACC_W + 1)'(NUM_CH)) begin
            acc_d = ACC_W'(sum - (ACC_W + 1)'(NUM_CH));
            mix_d = enable;
        end else begin
            acc_d = sum[ACC_W-1:0];
            mix_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    always_comb begin
        mix_d = enable & (|tone_q);
    end
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= ST_IDLE;
                hp_q[c]    <= '0;
                phase_q[c] <= '0;
                dur_q[c]   <= '0;
            end
            wave_q  <= '0;
            tone_q  <= '0;
            busy_q  <= '0;
            ready_q <= 1'b0;
            mix_q   <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                hp_q[c]    <= hp_d[c];
                phase_q[c] <= phase_d[c];
                dur_q[c]   <= dur_d[c];
            end
            wave_q  <= wave_d;
            tone_q  <= tone_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            mix_q   <= mix_d;
        end
    end

    assign cfg_ready = ready_q;
    assign tone_out  = tone_q;
    assign busy      = busy_q;
    assign mix_out   = mix_q;

endmodule
